// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter with timed access to a memory region and an IO region.
// Optional macro BUS_ARB_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has fixed priority.
module bus_arbiter #(
    parameter logic [7:0] IO_START_ADDR  = 8'h00,
    parameter logic [7:0] IO_STOP_ADDR   = 8'h3F,
    parameter logic [7:0] MEM_START_ADDR = 8'h40,
    parameter logic [7:0] MEM_STOP_ADDR  = 8'hBF,
    parameter int         DATA_WIDTH     = 8,
    parameter int         ADDR_WIDTH     = 16,
    parameter int         WAIT_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  io_cs,
    output logic                  io_we,
    output logic                  io_oe,
    output logic [1:0]            dbg_state_o
);

    // Request handshake: reqN is held until doneN; doneN is a single-cycle pulse.
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    sel_q, sel_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    win;
    logic [ADDR_WIDTH-1:0]   mem_off, io_off;
    logic                    mem_hit, io_hit, in_access;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Under contention, the requester that did not win last time gets the bus.
    assign win = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_q <= 1'b1;
        else if (state_q == S_IDLE && (req0 || req1))
            last_q <= win;
    end
`else
    assign win = ~req0;
`endif

    // Offset-based range checks avoid constant comparisons when a region starts at 0.
    assign mem_off   = addr_q - ADDR_WIDTH'(MEM_START_ADDR);
    assign io_off    = addr_q - ADDR_WIDTH'(IO_START_ADDR);
    assign mem_hit   = mem_off <= ADDR_WIDTH'(MEM_STOP_ADDR - MEM_START_ADDR);
    assign io_hit    = !mem_hit && (io_off <= ADDR_WIDTH'(IO_STOP_ADDR - IO_START_ADDR));
    assign in_access = (state_q == S_ACCESS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    sel_d   = win;
                    we_d    = win ? we1 : we0;
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                    if (!we_q || !(mem_hit || io_hit))
                        rdata_d = (mem_hit || io_hit) ? bus_data : '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt0        = (state_q != S_IDLE) && !sel_q;
    assign gnt1        = (state_q != S_IDLE) && sel_q;
    assign done0       = (state_q == S_DONE) && !sel_q;
    assign done1       = (state_q == S_DONE) && sel_q;
    assign err         = (state_q == S_DONE) && !(mem_hit || io_hit);
    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

    assign mem_cs   = in_access && mem_hit;
    assign mem_we   = in_access && mem_hit && we_q;
    assign mem_oe   = in_access && mem_hit && !we_q;
    assign io_cs    = in_access && io_hit;
    assign io_we    = in_access && io_hit && we_q;
    assign io_oe    = in_access && io_hit && !we_q;
    assign bus_addr = !in_access ? '0 : mem_hit ? mem_off : io_hit ? io_off : '0;
    assign bus_data = (in_access && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter IO_START_ADDR, default 8'h00, first IO address.
REQ-002 SHALL have parameter IO_STOP_ADDR, default 8'h3F, last IO address.
REQ-003 SHALL have parameter MEM_START_ADDR, default 8'h40, first data-memory address.
REQ-004 SHALL have parameter MEM_STOP_ADDR, default 8'hBF, last data-memory address.
REQ-005 SHALL have parameter DATA_WIDTH, default 8, data bus width.
REQ-006 SHALL have parameter ADDR_WIDTH, default 16, address width.
REQ-007 SHALL have parameter WAIT_CYCLES, default 2, extra access cycles per transfer (0..15).
REQ-008 SHALL have ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- reqN  input  1  requester N (N=0,1) transfer request, held until doneN.
- weN  input  1  requester N write (1) / read (0).
- addrN  input  ADDR_WIDTH  requester N flat address.
- wdataN  input  DATA_WIDTH  requester N write data.
- gntN  output  1  requester N owns bus for current transfer.
- doneN  output  1  one-cycle completion pulse to requester N.
- rdata  output  DATA_WIDTH  read data, valid while doneN high.
- err  output  1  one-cycle pulse with doneN when address unmapped.
- bus_addr  output  ADDR_WIDTH  region-relative address.
- bus_data  inout  DATA_WIDTH  shared data bus.
- mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe  output  1 each  device strobes.

Function
REQ-009 SHALL implement states IDLE, ACCESS, DONE; arbitration SHALL occur only in IDLE.
REQ-010 In IDLE, at a rising edge with any reqN high, SHALL select winner, latch its we/addr/wdata, set gntN, enter ACCESS.
REQ-011 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by an internal counter; then DONE.
REQ-012 DONE SHALL last one cycle, assert doneN for the granted requester, clear gntN on exit, return to IDLE.
REQ-013 Latency: req sampled at edge E0 -> doneN high during cycle E0+WAIT_CYCLES+1 to E0+WAIT_CYCLES+2; next grant no earlier than edge E0+WAIT_CYCLES+3.
REQ-014 Decode on latched address: MEM_START_ADDR..MEM_STOP_ADDR -> mem region, bus_addr = addr-MEM_START_ADDR; IO_START_ADDR..IO_STOP_ADDR -> IO region, bus_addr = addr-IO_START_ADDR.
REQ-015 During ACCESS only: selected cs=1, we=latched we, oe=~latched we; the other region's strobes SHALL be 0.
REQ-016 bus_data SHALL be driven with latched wdata only during ACCESS of a write; high-Z otherwise.
REQ-017 On a read, rdata SHALL capture bus_data on the last ACCESS edge and hold until next read completes.
REQ-018 Unmapped address: no strobes, ACCESS still timed, err=1 and rdata=0 in DONE.
REQ-019 Outside ACCESS all strobes SHALL be 0 and bus_addr SHALL be 0 (never X).
REQ-020 reqN dropping during ACCESS SHALL NOT abort; transfer completes and doneN pulses.
REQ-021 Single requester active SHALL always win regardless of arbitration mode.

Reset
REQ-022 reset high SHALL immediately force IDLE, counter 0, all gntN/doneN/err/strobes 0, bus_addr 0, rdata 0, bus_data high-Z, last-grant pointer to 1.
REQ-023 Reset mid-transfer SHALL drop the transfer with no doneN pulse.

Configuration
REQ-024 Macro BUS_ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL grant the requester not granted last (pointer updated on each grant); first contention after reset grants requester 0.
REQ-025 Macro undefined: simultaneous requests SHALL always grant requester 0; pointer logic absent.

Verification
REQ-026 req0 write addr0=16'h0045 wdata0=8'hA5, WAIT_CYCLES=2 -> mem_cs=mem_we=1, bus_addr=16'h0005, bus_data=8'hA5 for 3 cycles; done0 pulse at cycle 4.
REQ-027 req1 read addr1=16'h0010, device drives 8'h3C -> io_cs=io_oe=1, bus_addr=16'h0010; rdata=8'h3C with done1.
REQ-028 req0 and req1 held high continuously, reads -> with macro grants alternate 0,1,0,1; without macro only requester 0 served.
REQ-029 req0 read addr0=16'h00C0 -> no strobes, done0 and err pulse together, rdata=8'h00.
REQ-030 reset asserted in second ACCESS cycle -> strobes 0 and gnt0 0 same cycle, no done0; fresh req0 after release completes normally.
REQ-031 req0 deasserted one cycle after grant -> transfer completes, done0 pulses once.
